vga_scanout: RTL

- Parametrised VGA timing generator and framebuffer reader.
- Successor to the fixed 640x480 VGA block.
- Reads packed pixels from port B of the dual-port video RAM and drives 4-bit R/G/B plus HS/VS.
- Adds configurable timing, pixel depth, integer pixel replication, RAM read-latency compensation, an enable control and a frame-start strobe.

---
 rtl/vga_scanout_if.sv | 18 +
 rtl/vga_scanout.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout_if.sv
// Video RAM read port and VGA pin bundle used by vga_scanout.
// master = scanout engine, slave = RAM / display side.
interface vga_scanout_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] q;
  logic [3:0]        VGA_R;
  logic [3:0]        VGA_G;
  logic [3:0]        VGA_B;
  logic              HS;
  logic              VS;
  logic              frame_start;

  modport master (output address, input q, output VGA_R, VGA_G, VGA_B, HS, VS, frame_start);
  modport slave  (input address, output q, input VGA_R, VGA_G, VGA_B, HS, VS, frame_start);
endinterface

// File: rtl/vga_scanout.sv
// Parametrised VGA timing generator and packed-pixel framebuffer reader.
// Optional 16-entry colour palette enabled by defining VGA_SCANOUT_PALETTE_EN.
module vga_scanout #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int PIX_W     = 4,
  parameter int SCALE     = 2,
  parameter int BASE_ADDR = 0,
  parameter int RAM_LAT   = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
`ifdef VGA_SCANOUT_PALETTE_EN
  input  logic          pal_we,
  input  logic [3:0]    pal_addr,
  input  logic [11:0]   pal_data,
`endif
  vga_scanout_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LW      = H_ACTIVE / SCALE;
  localparam int PPW     = DATA_W / PIX_W;
  localparam int PPW_SH  = $clog2(PPW);
  localparam int SLOT_W  = (PPW > 1) ? PPW_SH : 1;
  localparam int HC_W    = $clog2(H_TOTAL + 1);
  localparam int VC_W    = $clog2(V_TOTAL + 1);
  localparam int SC_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int IDX_W   = ADDR_W + PPW_SH;

  localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT_END  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] H_ACT_LAST = HC_W'(H_ACTIVE - 1);
  localparam logic [HC_W-1:0] HS_START   = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END     = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT_END  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] V_ACT_LAST = VC_W'(V_ACTIVE - 1);
  localparam logic [VC_W-1:0] VS_START   = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END     = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SC_W-1:0] SUB_LAST   = SC_W'(SCALE - 1);
  localparam logic [IDX_W-1:0] LW_C      = IDX_W'(LW);
  localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);
  localparam logic SYNC_OFF              = !SYNC_POL;

  typedef struct packed {
    logic              act;
    logic              hs;
    logic              vs;
    logic              fs;
    logic [SLOT_W-1:0] slot;
  } ctl_t;

  logic [HC_W-1:0]   h_cnt_r;
  logic [VC_W-1:0]   v_cnt_r;
  logic [SC_W-1:0]   h_sub_r;
  logic [SC_W-1:0]   v_sub_r;
  logic [IDX_W-1:0]  x_r;
  logic [IDX_W-1:0]  line_start_r;
  logic [IDX_W-1:0]  idx_s;
  ctl_t              ctl_s;
  ctl_t              ctl_pipe_r [RAM_LAT+1];
  logic [ADDR_W-1:0] address_r;
  logic [3:0]        pix_s;
  logic [11:0]       colour_s;
  logic [3:0]        r_r;
  logic [3:0]        g_r;
  logic [3:0]        b_r;
  logic              hs_r;
  logic              vs_r;
  logic              fs_r;

  function automatic logic [3:0] pix_pick(input logic [DATA_W-1:0] word, input logic [SLOT_W-1:0] slot);
    logic [3:0] p;
    p = 4'h0;
    for (int i = 0; i < PPW; i++) begin
      if (slot == SLOT_W'(i)) p[PIX_W-1:0] = word[i*PIX_W +: PIX_W];
    end
    return p;
  endfunction

  // Left-align the pixel and replicate its bits to fill a 4-bit channel.
  function automatic logic [3:0] grey(input logic [3:0] p);
    logic [3:0] g;
    case (PIX_W)
      32'd1:   g = {4{p[0]}};
      32'd2:   g = {p[1:0], p[1:0]};
      default: g = p;
    endcase
    return g;
  endfunction

  // Raster counters plus scaled x position and line-start accumulator (stands in for y*LW).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_r      <= '0;
      v_cnt_r      <= '0;
      h_sub_r      <= '0;
      v_sub_r      <= '0;
      x_r          <= '0;
      line_start_r <= '0;
    end else if (!enable) begin
      h_cnt_r      <= '0;
      v_cnt_r      <= '0;
      h_sub_r      <= '0;
      v_sub_r      <= '0;
      x_r          <= '0;
      line_start_r <= '0;
    end else begin
      if (h_cnt_r == H_LAST) begin
        h_cnt_r <= '0;
        if (v_cnt_r == V_LAST) begin
          v_cnt_r <= '0;
          v_sub_r <= '0;
        end else begin
          v_cnt_r <= v_cnt_r + VC_W'(1);
          v_sub_r <= (v_sub_r == SUB_LAST) ? '0 : v_sub_r + SC_W'(1);
        end
      end else begin
        h_cnt_r <= h_cnt_r + HC_W'(1);
      end

      if (h_cnt_r == H_ACT_LAST) begin
        h_sub_r <= '0;
        x_r     <= '0;
      end else if ((h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END)) begin
        if (h_sub_r == SUB_LAST) begin
          h_sub_r <= '0;
          x_r     <= x_r + IDX_W'(1);
        end else begin
          h_sub_r <= h_sub_r + SC_W'(1);
        end
      end

      // After the last visible line the next line to fetch is the top of the next frame.
      if ((h_cnt_r == H_LAST) && (v_cnt_r == V_LAST)) begin
        line_start_r <= '0;
      end else if ((h_cnt_r == H_ACT_LAST) && (v_cnt_r < V_ACT_END) && (v_sub_r == SUB_LAST)) begin
        line_start_r <= (v_cnt_r == V_ACT_LAST) ? '0 : line_start_r + LW_C;
      end
    end
  end

  // Stage-0 control word derived from the counters.
  always_comb begin
    idx_s     = line_start_r + x_r;
    ctl_s     = '0;
    ctl_s.act = enable && (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
    ctl_s.hs  = enable && (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
    ctl_s.vs  = enable && (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
    ctl_s.fs  = enable && (h_cnt_r == '0) && (v_cnt_r == '0);
    ctl_s.slot = idx_s[SLOT_W-1:0];
  end

  // Address register and control delay line matching the RAM read latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address_r <= BASE_C;
      for (int i = 0; i <= RAM_LAT; i++) ctl_pipe_r[i] <= '0;
    end else begin
      address_r     <= BASE_C + ADDR_W'(idx_s >> PPW_SH);
      ctl_pipe_r[0] <= ctl_s;
      for (int i = 1; i <= RAM_LAT; i++) ctl_pipe_r[i] <= ctl_pipe_r[i-1];
    end
  end

`ifdef VGA_SCANOUT_PALETTE_EN
  logic [11:0] pal_r [16];

  // Palette register file, reset to the grey ramp.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) pal_r[i] <= {3{4'(i)}};
    end else if (pal_we) begin
      pal_r[pal_addr] <= pal_data;
    end
  end
`endif

  // Pixel extraction from the RAM word and colour mapping.
  always_comb begin
    pix_s = pix_pick(vga.q, ctl_pipe_r[RAM_LAT].slot);
`ifdef VGA_SCANOUT_PALETTE_EN
    colour_s = pal_r[pix_s];
`else
    colour_s = {3{grey(pix_s)}};
`endif
  end

  // Output register driving the VGA pins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_r  <= 4'h0;
      g_r  <= 4'h0;
      b_r  <= 4'h0;
      hs_r <= SYNC_OFF;
      vs_r <= SYNC_OFF;
      fs_r <= 1'b0;
    end else begin
      r_r  <= ctl_pipe_r[RAM_LAT].act ? colour_s[11:8] : 4'h0;
      g_r  <= ctl_pipe_r[RAM_LAT].act ? colour_s[7:4]  : 4'h0;
      b_r  <= ctl_pipe_r[RAM_LAT].act ? colour_s[3:0]  : 4'h0;
      hs_r <= ctl_pipe_r[RAM_LAT].hs ? SYNC_POL : SYNC_OFF;
      vs_r <= ctl_pipe_r[RAM_LAT].vs ? SYNC_POL : SYNC_OFF;
      fs_r <= ctl_pipe_r[RAM_LAT].fs;
    end
  end

  assign vga.address     = address_r;
  assign vga.VGA_R       = r_r;
  assign vga.VGA_G       = g_r;
  assign vga.VGA_B       = b_r;
  assign vga.HS          = hs_r;
  assign vga.VS          = vs_r;
  assign vga.frame_start = fs_r;

endmodule
